// File: rtl/risc_pkg.sv
// Shared types and encodings for the Simple RISC Machine controller:
// FSM states, opcode/op field values and write-back source selects.
package risc_pkg;

  localparam int DATA_WIDTH = 16;

  typedef enum logic [2:0] {
    S_WAIT      = 3'd0,
    S_DECODE    = 3'd1,
    S_WRITE_IMM = 3'd2,
    S_GET_A     = 3'd3,
    S_GET_B     = 3'd4,
    S_EXEC      = 3'd5,
    S_WRITE_REG = 3'd6
  } state_t;

  localparam logic [2:0] OPC_MOV = 3'b110;
  localparam logic [2:0] OPC_ALU = 3'b101;

  localparam logic [1:0] OP_MOV_IMM = 2'b10;
  localparam logic [1:0] OP_MOV_REG = 2'b00;
  localparam logic [1:0] OP_ADD     = 2'b00;
  localparam logic [1:0] OP_CMP     = 2'b01;
  localparam logic [1:0] OP_AND     = 2'b10;
  localparam logic [1:0] OP_MVN     = 2'b11;

  localparam logic [1:0] VSEL_C     = 2'b00;
  localparam logic [1:0] VSEL_PC    = 2'b01;
  localparam logic [1:0] VSEL_IMM8  = 2'b10;
  localparam logic [1:0] VSEL_MDATA = 2'b11;

  function automatic logic legal_instr(input logic [2:0] opcode, input logic [1:0] op);
    return (opcode == OPC_ALU) ||
           (opcode == OPC_MOV && (op == OP_MOV_IMM || op == OP_MOV_REG));
  endfunction

endpackage

// File: rtl/risc_controller_instr_dec.sv
// Combinational instruction decoder: splits IR into register fields,
// sign-extended immediates, shifter/ALU controls and instruction-class flags.
module instr_dec
  import risc_pkg::*;
#(
  parameter int data_width = DATA_WIDTH
) (
  input  logic [15:0]           ir,
  output logic [2:0]            rn,
  output logic [2:0]            rd,
  output logic [2:0]            rm,
  output logic [data_width-1:0] sximm5,
  output logic [data_width-1:0] sximm8,
  output logic [2:0]            shift,
  output logic [2:0]            alu_op,
  output logic                  is_mov_imm,
  output logic                  is_mov_reg,
  output logic                  is_unary,
  output logic                  is_binary,
  output logic                  is_cmp
);

  logic [2:0] opcode;
  logic [1:0] op;

  assign opcode = ir[15:13];
  assign op     = ir[12:11];
  assign rn     = ir[10:8];
  assign rd     = ir[7:5];
  assign rm     = ir[2:0];

  assign sximm8 = {{(data_width-8){ir[7]}}, ir[7:0]};
  assign sximm5 = {{(data_width-5){ir[4]}}, ir[4:0]};
  assign shift  = {1'b0, ir[4:3]};
  assign alu_op = (opcode == OPC_ALU) ? {1'b0, op} : 3'b000;

  assign is_mov_imm = (opcode == OPC_MOV) && (op == OP_MOV_IMM);
  assign is_mov_reg = (opcode == OPC_MOV) && (op == OP_MOV_REG);
  // Single-operand forms skip the A read and go straight to fetching Rm.
  assign is_unary   = is_mov_reg || ((opcode == OPC_ALU) && (op == OP_MVN));
  assign is_binary  = (opcode == OPC_ALU) && (op != OP_MVN);
  assign is_cmp     = (opcode == OPC_ALU) && (op == OP_CMP);

endmodule

// File: rtl/risc_controller.sv
// Instruction register and control FSM for the Simple RISC Machine datapath.
// Every control output is a register loaded with the value for the state being entered.
module risc_controller
  import risc_pkg::*;
#(
  parameter int data_width = DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  s,
  input  logic [15:0]           in,
  output logic                  w,
  output logic                  illegal,
  output logic [2:0]            readnum,
  output logic [2:0]            writenum,
  output logic                  write,
  output logic                  loada,
  output logic                  loadb,
  output logic                  loadc,
  output logic                  loads,
  output logic                  asel,
  output logic                  bsel,
  output logic [1:0]            vsel,
  output logic [2:0]            ALUop,
  output logic [2:0]            shift,
  output logic [data_width-1:0] sximm5,
  output logic [data_width-1:0] sximm8,
  output logic [2:0]            dbg_state
);

  state_t      state;
  logic [15:0] ir;
  logic [2:0]  rn, rd, rm;
  logic        is_mov_imm, is_mov_reg, is_unary, is_binary, is_cmp;

  assign dbg_state = state;

  instr_dec #(.data_width(data_width)) u_dec (
    .ir         (ir),
    .rn         (rn),
    .rd         (rd),
    .rm         (rm),
    .sximm5     (sximm5),
    .sximm8     (sximm8),
    .shift      (shift),
    .alu_op     (ALUop),
    .is_mov_imm (is_mov_imm),
    .is_mov_reg (is_mov_reg),
    .is_unary   (is_unary),
    .is_binary  (is_binary),
    .is_cmp     (is_cmp)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_WAIT;
      ir       <= 16'h0000;
      w        <= 1'b1;
      illegal  <= 1'b0;
      readnum  <= 3'd0;
      writenum <= 3'd0;
      write    <= 1'b0;
      loada    <= 1'b0;
      loadb    <= 1'b0;
      loadc    <= 1'b0;
      loads    <= 1'b0;
      asel     <= 1'b0;
      bsel     <= 1'b0;
      vsel     <= VSEL_C;
    end else begin
      w        <= 1'b0;
      illegal  <= 1'b0;
      readnum  <= 3'd0;
      writenum <= 3'd0;
      write    <= 1'b0;
      loada    <= 1'b0;
      loadb    <= 1'b0;
      loadc    <= 1'b0;
      loads    <= 1'b0;
      asel     <= 1'b0;
      bsel     <= 1'b0;
      vsel     <= VSEL_C;
      case (state)
        S_WAIT: begin
          if (s) begin
            ir    <= in;
            state <= S_DECODE;
            // IR is not loaded yet, so the illegal flag for S_DECODE comes from the raw input.
            illegal <= !legal_instr(in[15:13], in[12:11]);
          end else begin
            w <= 1'b1;
          end
        end
        S_DECODE: begin
          if (is_mov_imm) begin
            state    <= S_WRITE_IMM;
            writenum <= rn;
            vsel     <= VSEL_IMM8;
            write    <= 1'b1;
          end else if (is_unary) begin
            state   <= S_GET_B;
            readnum <= rm;
            loadb   <= 1'b1;
          end else if (is_binary) begin
            state   <= S_GET_A;
            readnum <= rn;
            loada   <= 1'b1;
          end else begin
            state <= S_WAIT;
            w     <= 1'b1;
          end
        end
        S_GET_A: begin
          state   <= S_GET_B;
          readnum <= rm;
          loadb   <= 1'b1;
        end
        S_GET_B: begin
          state <= S_EXEC;
          asel  <= is_mov_reg;
          loads <= is_cmp;
          loadc <= !is_cmp;
        end
        S_EXEC: begin
          if (is_cmp) begin
            state <= S_WAIT;
            w     <= 1'b1;
          end else begin
            state    <= S_WRITE_REG;
            writenum <= rd;
            vsel     <= VSEL_C;
            write    <= 1'b1;
          end
        end
        default: begin
          state <= S_WAIT;
          w     <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_risc_controller.sv
// Bench for risc_controller: directed instructions then random ones, each
// expanded into an expected per-cycle control trace after the accept edge.
module tb_risc_controller;
  import risc_pkg::*;

  typedef struct packed {
    logic       w;
    logic       illegal;
    logic       write;
    logic       loada;
    logic       loadb;
    logic       loadc;
    logic       loads;
    logic       asel;
    logic       bsel;
    logic [1:0] vsel;
    logic [2:0] readnum;
    logic [2:0] writenum;
  } ctl_t;

  localparam int CW = $bits(ctl_t);

  logic        clk = 1'b0;
  logic        reset;
  logic        s;
  logic [15:0] instr_in;
  logic        w, illegal, write, loada, loadb, loadc, loads, asel, bsel;
  logic [2:0]  readnum, writenum, ALUop, shift, dbg_state;
  logic [1:0]  vsel;
  logic [15:0] sximm5, sximm8;

  logic [CW-1:0] exp_q[$];
  logic [15:0]   model_ir;
  int            checks = 0;
  int            errors = 0;

  always #5 clk = ~clk;

  risc_controller #(.data_width(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .s         (s),
    .in        (instr_in),
    .w         (w),
    .illegal   (illegal),
    .readnum   (readnum),
    .writenum  (writenum),
    .write     (write),
    .loada     (loada),
    .loadb     (loadb),
    .loadc     (loadc),
    .loads     (loads),
    .asel      (asel),
    .bsel      (bsel),
    .vsel      (vsel),
    .ALUop     (ALUop),
    .shift     (shift),
    .sximm5    (sximm5),
    .sximm8    (sximm8),
    .dbg_state (dbg_state)
  );

  // Immediates and ALU controls derived from the architectural IR with plain arithmetic.
  function automatic logic [37:0] imm_model(input logic [15:0] i);
    int v8, v5;
    logic [15:0] e8, e5;
    logic [2:0]  alu;
    v8 = int'(i[7:0]) - (i[7] ? 256 : 0);
    v5 = int'(i[4:0]) - (i[4] ? 32 : 0);
    e8 = 16'(v8);
    e5 = 16'(v5);
    alu = (i[15:13] == 3'b101) ? {1'b0, i[12:11]} : 3'b000;
    return {e8, e5, {1'b0, i[4:3]}, alu};
  endfunction

  task automatic push_expected(input logic [15:0] i);
    logic [2:0] opc;
    logic [1:0] op;
    ctl_t c;
    opc = i[15:13];
    op  = i[12:11];
    c = '0;
    if (opc == 3'b110 && op == 2'b10) begin
      exp_q.push_back(c);
      c.write = 1'b1; c.writenum = i[10:8]; c.vsel = 2'b10;
      exp_q.push_back(c);
    end else if ((opc == 3'b110 && op == 2'b00) || (opc == 3'b101 && op == 2'b11)) begin
      exp_q.push_back(c);
      c.loadb = 1'b1; c.readnum = i[2:0];
      exp_q.push_back(c);
      c = '0; c.loadc = 1'b1; c.asel = (opc == 3'b110);
      exp_q.push_back(c);
      c = '0; c.write = 1'b1; c.writenum = i[7:5];
      exp_q.push_back(c);
    end else if (opc == 3'b101) begin
      exp_q.push_back(c);
      c.loada = 1'b1; c.readnum = i[10:8];
      exp_q.push_back(c);
      c = '0; c.loadb = 1'b1; c.readnum = i[2:0];
      exp_q.push_back(c);
      c = '0;
      if (op == 2'b01) c.loads = 1'b1;
      else c.loadc = 1'b1;
      exp_q.push_back(c);
      if (op != 2'b01) begin
        c = '0; c.write = 1'b1; c.writenum = i[7:5];
        exp_q.push_back(c);
      end
    end else begin
      c.illegal = 1'b1;
      exp_q.push_back(c);
    end
    c = '0; c.w = 1'b1;
    exp_q.push_back(c);
  endtask

  task automatic check_cycle(input string tag);
    logic [CW-1:0] exp_c, obs_c;
    logic [37:0]   exp_i, obs_i;
    @(negedge clk);
    exp_c = exp_q.pop_front();
    obs_c = {w, illegal, write, loada, loadb, loadc, loads, asel, bsel, vsel, readnum, writenum};
    checks++;
    assert (obs_c === exp_c) else begin
      errors++;
      $error("FAIL %s ctl ir=%h observed=%h expected=%h", tag, model_ir, obs_c, exp_c);
    end
    exp_i = imm_model(model_ir);
    obs_i = {sximm8, sximm5, shift, ALUop};
    checks++;
    assert (obs_i === exp_i) else begin
      errors++;
      $error("FAIL %s imm ir=%h observed=%h expected=%h", tag, model_ir, obs_i, exp_i);
    end
  endtask

  // Called at a negedge in the idle state; s is random while busy to show it is ignored.
  task automatic run_instr(input logic [15:0] i, input string tag);
    s = 1'b1;
    instr_in = i;
    model_ir = i;
    push_expected(i);
    while (exp_q.size() > 0) begin
      check_cycle(tag);
      if (exp_q.size() > 0) begin
        s = 1'($urandom_range(0, 1));
        instr_in = 16'($urandom);
      end
    end
    s = 1'b0;
  endtask

  task automatic idle_cycle(input string tag);
    ctl_t c;
    s = 1'b0;
    instr_in = 16'($urandom);
    c = '0; c.w = 1'b1;
    exp_q.push_back(c);
    check_cycle(tag);
  endtask

  initial begin
    logic [15:0] directed [6];
    logic [15:0] ri;
    ctl_t c;
    directed = '{16'hD007, 16'hD1FE, 16'hA148, 16'hA900, 16'hB860, 16'h0000};

    reset = 1'b1;
    s = 1'b0;
    instr_in = 16'h0000;
    model_ir = 16'h0000;
    repeat (2) @(negedge clk);
    c = '0; c.w = 1'b1;
    exp_q.push_back(c);
    check_cycle("reset");
    checks++;
    assert (dbg_state === 3'(S_WAIT)) else begin
      errors++;
      $error("FAIL reset_state observed=%0d expected=%0d", dbg_state, 3'(S_WAIT));
    end
    reset = 1'b0;
    idle_cycle("idle_after_reset");

    foreach (directed[k]) begin
      run_instr(directed[k], "directed");
      idle_cycle("directed_gap");
    end

    // Back-to-back: s held high across the one idle cycle between instructions.
    run_instr(16'hA148, "b2b_add");
    run_instr(16'hB860, "b2b_mvn");
    run_instr(16'hD1FE, "b2b_movi");

    // Reset while an ADD sits in S_GET_B abandons it.
    s = 1'b1;
    instr_in = 16'hA148;
    model_ir = 16'hA148;
    push_expected(16'hA148);
    repeat (3) begin
      check_cycle("rst_mid_pre");
      s = 1'($urandom_range(0, 1));
      instr_in = 16'($urandom);
    end
    exp_q.delete();
    reset = 1'b1;
    s = 1'b0;
    model_ir = 16'h0000;
    c = '0; c.w = 1'b1;
    exp_q.push_back(c);
    check_cycle("rst_mid");
    checks++;
    assert (dbg_state === 3'(S_WAIT)) else begin
      errors++;
      $error("FAIL rst_mid_state observed=%0d expected=%0d", dbg_state, 3'(S_WAIT));
    end
    reset = 1'b0;
    idle_cycle("rst_mid_after");
    idle_cycle("rst_mid_after");

    for (int n = 0; n < 80; n++) begin
      case ($urandom_range(0, 7))
        0: ri = {3'b110, 2'b10, 11'($urandom)};
        1: ri = {3'b110, 2'b00, 11'($urandom)};
        2: ri = {3'b101, 2'b00, 11'($urandom)};
        3: ri = {3'b101, 2'b01, 11'($urandom)};
        4: ri = {3'b101, 2'b10, 11'($urandom)};
        5: ri = {3'b101, 2'b11, 11'($urandom)};
        default: ri = 16'($urandom);
      endcase
      if ($urandom_range(0, 2) == 0) begin
        repeat ($urandom_range(1, 3)) idle_cycle("rand_gap");
      end
      run_instr(ri, "random");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
